// File: rtl/ir_fetch_reader_pkg.sv
// Constants shared by the IR loader, this fetch reader and the execute stage:
// word width, opcodes and the fetch FSM encoding.
package ir_fetch_reader_pkg;

  localparam int IR_DATA_WIDTH = 8;
  localparam int IR_ADDR_WIDTH = 8;

  localparam logic [7:0] LOAD = 8'h01;
  localparam logic [7:0] HALT = 8'h0F;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    STALL = 3'd1,
    RD_IR = 3'd2,
    RD_P0 = 3'd3,
    RD_P1 = 3'd4,
    RD_P2 = 3'd5,
    LAST  = 3'd6,
    VALID = 3'd7
  } fetch_state_t;

endpackage

// File: rtl/ir_fetch_reader.sv
// Walks a PC through the IR regfile, assembles 4-word instructions and offers them
// on valid/ready; 6 cycles from start to valid, holds in VALID while ir_ready is low.
module ir_fetch_reader
  import ir_fetch_reader_pkg::*;
#(
  parameter int DATA_WIDTH = IR_DATA_WIDTH,
  parameter int ADDR_WIDTH = IR_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic                  flush,
  input  logic                  load_busy,
  output logic                  o_ir_regfile_ren,
  output logic [ADDR_WIDTH-1:0] o_ir_regfile_addr,
  input  logic [DATA_WIDTH-1:0] ir_regfile_data,
  output logic [DATA_WIDTH-1:0] o_ir,
  output logic [DATA_WIDTH-1:0] o_p0,
  output logic [DATA_WIDTH-1:0] o_p1,
  output logic [DATA_WIDTH-1:0] o_p2,
  output logic                  o_ir_valid,
  input  logic                  ir_ready,
  input  logic                  jump,
  input  logic [ADDR_WIDTH-1:0] jump_addr,
  output logic                  o_busy
);

  fetch_state_t          state, state_nxt;
  logic [ADDR_WIDTH-1:0] pc;
  logic                  handshake;
  logic                  is_halt;

  assign handshake = (state == VALID) && ir_ready;
  assign is_halt   = (o_ir == DATA_WIDTH'(HALT));

  always_comb begin
    state_nxt         = state;
    o_ir_regfile_ren  = 1'b0;
    o_ir_regfile_addr = '0;
    o_ir_valid        = 1'b0;
    o_busy            = (state != IDLE);
    case (state)
      IDLE:    if (start) state_nxt = load_busy ? STALL : RD_IR;
      STALL:   if (!load_busy) state_nxt = RD_IR;
      RD_IR:   state_nxt = RD_P0;
      RD_P0:   state_nxt = RD_P1;
      RD_P1:   state_nxt = RD_P2;
      RD_P2:   state_nxt = LAST;
      LAST:    state_nxt = VALID;
      VALID: begin
        o_ir_valid = 1'b1;
        if (handshake) begin
          if (is_halt)        state_nxt = IDLE;
          else if (load_busy) state_nxt = STALL;
          else                state_nxt = RD_IR;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (state == RD_IR || state == RD_P0 || state == RD_P1 || state == RD_P2) begin
      o_ir_regfile_ren  = 1'b1;
      o_ir_regfile_addr = pc;
    end
    if (flush) state_nxt = IDLE;
  end

  // A flush freezes pc and the field registers; read data arriving after it is dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      pc    <= '0;
      o_ir  <= '0;
      o_p0  <= '0;
      o_p1  <= '0;
      o_p2  <= '0;
    end else begin
      state <= state_nxt;
      if (!flush) begin
        case (state)
          IDLE:                      if (start) pc <= start_addr;
          RD_IR, RD_P0, RD_P1, RD_P2: pc <= pc + ADDR_WIDTH'(1);
          VALID:                     if (handshake && jump && !is_halt) pc <= jump_addr;
          default: ;
        endcase
        case (state)
          RD_P0:   o_ir <= ir_regfile_data;
          RD_P1:   o_p0 <= ir_regfile_data;
          RD_P2:   o_p1 <= ir_regfile_data;
          LAST:    o_p2 <= ir_regfile_data;
          default: ;
        endcase
      end
    end
  end

endmodule
